// File: rtl/fetch_ctrl_if.sv
// Bundle of the PC, imem, decode and control signals around the fetch controller.
interface fetch_ctrl_if #(
  parameter int unsigned PCW = 32,
  parameter int unsigned IW  = 32
);

  // program counter side
  logic [PCW-1:0] pc_in;
  logic           pc_stall;
  logic           pc_branch;
  logic [PCW-1:0] pc_branch_target;

  // instruction memory port
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_gnt;
  logic           imem_rvalid;
  logic [IW-1:0]  imem_rdata;

  // decode stage
  logic           if_valid;
  logic [IW-1:0]  if_instr;
  logic [PCW-1:0] if_pc;
  logic           if_ready;

  // execute / control
  logic           redirect;
  logic [PCW-1:0] redirect_pc;
  logic           halt_req;
  logic           halted;

  // fetch controller side
  modport master (
    input  pc_in,
    output pc_stall,
    output pc_branch,
    output pc_branch_target,
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output if_valid,
    output if_instr,
    output if_pc,
    input  if_ready,
    input  redirect,
    input  redirect_pc,
    input  halt_req,
    output halted
  );

  // surrounding pipeline / memory side
  modport slave (
    output pc_in,
    input  pc_stall,
    input  pc_branch,
    input  pc_branch_target,
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output if_ready,
    output redirect,
    output redirect_pc,
    output halt_req,
    input  halted
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: one outstanding imem fetch at the current PC, a one-entry
// instruction buffer toward decode, and PC stall/branch control from
// redirects and halt.
module fetch_ctrl #(
  parameter int unsigned PCW = 32,
  parameter int unsigned IW  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DELIVER = 2'd2,
    S_HALTED  = 2'd3
  } state_t;

  state_t         state;
  logic           drop;       // response of the in-flight fetch is wrong-path
  logic           halt_pend;  // halt requested, takes effect at next instruction boundary
  logic [PCW-1:0] req_pc;     // address of the in-flight fetch
  logic [PCW-1:0] buf_pc;
  logic [IW-1:0]  buf_instr;

  logic in_fetch;
  logic in_deliver;
  logic in_halted;
  logic handshake;

  // State decode; reset forces every control output to its idle value.
  assign in_fetch   = rst_n && (state == S_FETCH);
  assign in_deliver = rst_n && (state == S_DELIVER);
  assign in_halted  = rst_n && (state == S_HALTED);
  assign handshake  = in_deliver && bus.if_ready && !bus.redirect;

  // PC control: advance only on a decode handshake; redirect loads the target.
  assign bus.pc_stall         = !handshake;
  assign bus.pc_branch        = rst_n && bus.redirect && (state != S_HALTED);
  assign bus.pc_branch_target = bus.redirect_pc;

  // Request at the current PC unless halting or being redirected this cycle.
  assign bus.imem_req  = in_fetch && !halt_pend && !bus.redirect;
  assign bus.imem_addr = bus.pc_in;

  // Buffered instruction toward decode; a redirect hides it immediately.
  assign bus.if_valid = in_deliver && !bus.redirect;
  assign bus.if_instr = buf_instr;
  assign bus.if_pc    = buf_pc;

  assign bus.halted = in_halted;

  // Fetch sequencing, wrong-path tracking and halt bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      drop      <= 1'b0;
      halt_pend <= 1'b0;
      req_pc    <= '0;
      buf_pc    <= '0;
      buf_instr <= '0;
    end else begin
      // a redirect means everything since the halt was on the wrong path
      if (state != S_HALTED) begin
        if (bus.redirect) begin
          halt_pend <= 1'b0;
        end else if (bus.halt_req) begin
          halt_pend <= 1'b1;
        end
      end

      case (state)
        S_FETCH: begin
          if (halt_pend && !bus.redirect) begin
            state <= S_HALTED;
          end else if (!bus.redirect && bus.imem_gnt) begin
            req_pc <= bus.pc_in;
            state  <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (bus.imem_rvalid) begin
            if (drop || bus.redirect) begin
              drop  <= 1'b0;
              state <= S_FETCH;
            end else begin
              buf_instr <= bus.imem_rdata;
              buf_pc    <= req_pc;
              state     <= S_DELIVER;
            end
          end else if (bus.redirect) begin
            drop <= 1'b1;
          end
        end

        S_DELIVER: begin
          if (bus.redirect) begin
            state <= S_FETCH;
          end else if (bus.if_ready) begin
            state <= halt_pend ? S_HALTED : S_FETCH;
          end
        end

        S_HALTED: begin
          state <= S_HALTED;
        end

        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural program counter.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  int          hs_cnt;
  int          n_pass;
  int          n_total;

  fetch_ctrl_if #(.PCW(32), .IW(32)) bus ();

  fetch_ctrl #(.PCW(32), .IW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // program counter model driven by the controller's stall/branch
  always_ff @(posedge clk) begin
    if (!rst_n)              pc <= 32'h0;
    else if (bus.pc_branch)  pc <= bus.pc_branch_target;
    else if (!bus.pc_stall)  pc <= pc + 32'd4;
  end
  assign bus.pc_in = pc;

  // decode handshake counter
  always_ff @(posedge clk) begin
    if (bus.if_valid && bus.if_ready) hs_cnt <= hs_cnt + 1;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // grant the current request, then return rdata lat cycles later; ends in the next cycle
  task automatic fetch_word(input logic [31:0] data, input int lat);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    repeat (lat - 1) step();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    step();
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    step();
    #1;
    n_total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_imem_req got %0b want 0", bus.imem_req); else n_pass++;
    n_total++; if (bus.if_valid !== 1'b0) $display("FAIL rst_if_valid got %0b want 0", bus.if_valid); else n_pass++;
    n_total++; if (bus.pc_stall !== 1'b1) $display("FAIL rst_pc_stall got %0b want 1", bus.pc_stall); else n_pass++;
    n_total++; if (bus.pc_branch !== 1'b0) $display("FAIL rst_pc_branch got %0b want 0", bus.pc_branch); else n_pass++;
    n_total++; if (bus.halted !== 1'b0) $display("FAIL rst_halted got %0b want 0", bus.halted); else n_pass++;
    bus.redirect = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL rst_first_req got %0b want 1", bus.imem_req); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL rst_first_addr got %h want 00000000", bus.imem_addr); else n_pass++;
  endtask

  task automatic test_basic();
    int hs0;
    hs0 = hs_cnt;
    fetch_word(32'h0000_0013, 2);
    bus.if_ready = 1'b1;
    #1;
    n_total++; if (bus.if_valid !== 1'b1) $display("FAIL t1_if_valid got %0b want 1", bus.if_valid); else n_pass++;
    n_total++; if (bus.if_pc !== 32'h0) $display("FAIL t1_if_pc got %h want 00000000", bus.if_pc); else n_pass++;
    n_total++; if (bus.if_instr !== 32'h0000_0013) $display("FAIL t1_if_instr got %h want 00000013", bus.if_instr); else n_pass++;
    n_total++; if (bus.pc_stall !== 1'b0) $display("FAIL t1_pc_stall got %0b want 0", bus.pc_stall); else n_pass++;
    step();
    bus.if_ready = 1'b0;
    #1;
    n_total++; if (bus.if_valid !== 1'b0) $display("FAIL t1_if_valid_after got %0b want 0", bus.if_valid); else n_pass++;
    n_total++; if (bus.pc_stall !== 1'b1) $display("FAIL t1_pc_stall_after got %0b want 1", bus.pc_stall); else n_pass++;
    n_total++; if (hs_cnt !== hs0 + 1) $display("FAIL t1_handshakes got %0d want %0d", hs_cnt, hs0 + 1); else n_pass++;
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL t1_next_req got %0b want 1", bus.imem_req); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h4) $display("FAIL t1_next_addr got %h want 00000004", bus.imem_addr); else n_pass++;
  endtask

  task automatic test_backpressure();
    int hs0;
    hs0 = hs_cnt;
    fetch_word(32'hAAAA_0001, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (bus.if_valid !== 1'b1) $display("FAIL t2_hold_valid[%0d] got %0b want 1", i, bus.if_valid); else n_pass++;
      n_total++; if (bus.if_instr !== 32'hAAAA_0001) $display("FAIL t2_hold_instr[%0d] got %h want aaaa0001", i, bus.if_instr); else n_pass++;
      n_total++; if (bus.if_pc !== 32'h4) $display("FAIL t2_hold_pc[%0d] got %h want 00000004", i, bus.if_pc); else n_pass++;
      n_total++; if (bus.pc_stall !== 1'b1) $display("FAIL t2_hold_stall[%0d] got %0b want 1", i, bus.pc_stall); else n_pass++;
      n_total++; if (bus.imem_req !== 1'b0) $display("FAIL t2_hold_req[%0d] got %0b want 0", i, bus.imem_req); else n_pass++;
      step();
    end
    bus.if_ready = 1'b1;
    #1;
    n_total++; if (bus.pc_stall !== 1'b0) $display("FAIL t2_accept_stall got %0b want 0", bus.pc_stall); else n_pass++;
    step();
    bus.if_ready = 1'b0;
    #1;
    n_total++; if (hs_cnt !== hs0 + 1) $display("FAIL t2_handshakes got %0d want %0d", hs_cnt, hs0 + 1); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h8) $display("FAIL t2_next_addr got %h want 00000008", bus.imem_addr); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    int hs0;
    hs0 = hs_cnt;
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h100;
    #1;
    n_total++; if (bus.pc_branch !== 1'b1) $display("FAIL t3_branch got %0b want 1", bus.pc_branch); else n_pass++;
    n_total++; if (bus.pc_branch_target !== 32'h100) $display("FAIL t3_target got %h want 00000100", bus.pc_branch_target); else n_pass++;
    step();
    bus.redirect = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    n_total++; if (bus.pc_branch !== 1'b0) $display("FAIL t3_branch_pulse got %0b want 0", bus.pc_branch); else n_pass++;
    step();
    bus.imem_rvalid = 1'b0;
    #1;
    n_total++; if (bus.if_valid !== 1'b0) $display("FAIL t3_dropped_valid got %0b want 0", bus.if_valid); else n_pass++;
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL t3_req got %0b want 1", bus.imem_req); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h100) $display("FAIL t3_addr got %h want 00000100", bus.imem_addr); else n_pass++;
    n_total++; if (hs_cnt !== hs0) $display("FAIL t3_handshakes got %0d want %0d", hs_cnt, hs0); else n_pass++;
  endtask

  task automatic test_redirect_deliver();
    int hs0;
    hs0 = hs_cnt;
    fetch_word(32'h0000_0033, 2);
    bus.if_ready = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    #1;
    n_total++; if (bus.if_valid !== 1'b0) $display("FAIL t4_valid got %0b want 0", bus.if_valid); else n_pass++;
    n_total++; if (bus.pc_branch !== 1'b1) $display("FAIL t4_branch got %0b want 1", bus.pc_branch); else n_pass++;
    n_total++; if (bus.pc_stall !== 1'b1) $display("FAIL t4_stall got %0b want 1", bus.pc_stall); else n_pass++;
    step();
    bus.redirect = 1'b0;
    bus.if_ready = 1'b0;
    #1;
    n_total++; if (hs_cnt !== hs0) $display("FAIL t4_handshakes got %0d want %0d", hs_cnt, hs0); else n_pass++;
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL t4_req got %0b want 1", bus.imem_req); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h200) $display("FAIL t4_addr got %h want 00000200", bus.imem_addr); else n_pass++;
  endtask

  task automatic test_halt();
    int hs0;
    hs0 = hs_cnt;
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h0000_0055;
    step();
    bus.imem_rvalid = 1'b0;
    bus.if_ready = 1'b1;
    #1;
    n_total++; if (bus.if_valid !== 1'b1) $display("FAIL t5_valid got %0b want 1", bus.if_valid); else n_pass++;
    n_total++; if (bus.if_pc !== 32'h200) $display("FAIL t5_pc got %h want 00000200", bus.if_pc); else n_pass++;
    n_total++; if (bus.if_instr !== 32'h0000_0055) $display("FAIL t5_instr got %h want 00000055", bus.if_instr); else n_pass++;
    step();
    bus.if_ready = 1'b0;
    #1;
    n_total++; if (hs_cnt !== hs0 + 1) $display("FAIL t5_handshakes got %0d want %0d", hs_cnt, hs0 + 1); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) begin
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h400;
      end
      #1;
      n_total++; if (bus.halted !== 1'b1) $display("FAIL t5_halted[%0d] got %0b want 1", i, bus.halted); else n_pass++;
      n_total++; if (bus.imem_req !== 1'b0) $display("FAIL t5_req[%0d] got %0b want 0", i, bus.imem_req); else n_pass++;
      if (i == 10) begin
        n_total++; if (bus.pc_branch !== 1'b0) $display("FAIL t5_branch got %0b want 0", bus.pc_branch); else n_pass++;
      end
      step();
      bus.redirect = 1'b0;
    end
    #1;
    n_total++; if (bus.imem_addr !== 32'h204) $display("FAIL t5_pc_frozen got %h want 00000204", bus.imem_addr); else n_pass++;
  endtask

  task automatic test_halt_cancel_and_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    n_total++; if (bus.halted !== 1'b0) $display("FAIL t6_unhalt got %0b want 0", bus.halted); else n_pass++;
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h300;
    #1;
    n_total++; if (bus.pc_branch !== 1'b1) $display("FAIL t6_branch got %0b want 1", bus.pc_branch); else n_pass++;
    step();
    bus.redirect = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'h0BAD_0BAD;
    step();
    bus.imem_rvalid = 1'b0;
    #1;
    n_total++; if (bus.if_valid !== 1'b0) $display("FAIL t6_dropped_valid got %0b want 0", bus.if_valid); else n_pass++;
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL t6_resume_req got %0b want 1", bus.imem_req); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h300) $display("FAIL t6_resume_addr got %h want 00000300", bus.imem_addr); else n_pass++;
    fetch_word(32'h0000_0077, 1);
    bus.if_ready = 1'b1;
    #1;
    n_total++; if (bus.if_pc !== 32'h300) $display("FAIL t6_deliver_pc got %h want 00000300", bus.if_pc); else n_pass++;
    step();
    bus.if_ready = 1'b0;
    #1;
    n_total++; if (bus.halted !== 1'b0) $display("FAIL t6_not_halted got %0b want 0", bus.halted); else n_pass++;
    n_total++; if (bus.imem_addr !== 32'h304) $display("FAIL t6_next_addr got %h want 00000304", bus.imem_addr); else n_pass++;
    // reset while a fetch is in flight; its late response must be ignored
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    #1;
    n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL t6_rst_addr got %h want 00000000", bus.imem_addr); else n_pass++;
    step();
    bus.imem_rvalid = 1'b0;
    #1;
    n_total++; if (bus.if_valid !== 1'b0) $display("FAIL t6_rst_stale_valid got %0b want 0", bus.if_valid); else n_pass++;
    n_total++; if (bus.imem_req !== 1'b1) $display("FAIL t6_rst_req got %0b want 1", bus.imem_req); else n_pass++;
    fetch_word(32'h0000_0099, 1);
    bus.if_ready = 1'b1;
    #1;
    n_total++; if (bus.if_instr !== 32'h0000_0099) $display("FAIL t6_rst_instr got %h want 00000099", bus.if_instr); else n_pass++;
    n_total++; if (bus.if_pc !== 32'h0) $display("FAIL t6_rst_pc got %h want 00000000", bus.if_pc); else n_pass++;
    step();
    bus.if_ready = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    hs_cnt = 0;
    rst_n = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.if_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.halt_req = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_deliver();
    test_halt();
    test_halt_cancel_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
